// File: rtl/ldpc_encoder.sv
// Bit-serial systematic LDPC encoder, (2304,1536) rate-2/3, circulant generator.
// Ports: clk, cnt_rst (async, active-low), cnt_en, cnt_stop_val, mul_info_bits in; codeword out.
module ldpc_encoder #(
  parameter int N              = 2304,
  parameter int K              = 1536,
  parameter int COUNT_MAX_BITS = 12,
  parameter logic [K-1:0] GEN_ROW0 = K'(3)
) (
  input  logic                      clk,
  input  logic                      cnt_rst,
  input  logic                      cnt_en,
  input  logic [COUNT_MAX_BITS-1:0] cnt_stop_val,
  input  logic [K-1:0]              mul_info_bits,
  output logic [N-1:0]              codeword
);

  localparam int KW = $clog2(K);
  localparam int NW = $clog2(N);
  localparam logic [COUNT_MAX_BITS-1:0] N_C = COUNT_MAX_BITS'(N);
  localparam logic [COUNT_MAX_BITS-1:0] K_C = COUNT_MAX_BITS'(K);

  logic [COUNT_MAX_BITS-1:0] cnt_q, cnt_d;
  logic [K-1:0]              info_q, info_d;
  logic [K-1:0]              grow_q, grow_d;
  logic [N-1:0]              cw_q, cw_d;

  logic [COUNT_MAX_BITS-1:0] stop_eff;
  logic                      step;
  logic                      sys_ph;
  logic [KW-1:0]             info_idx;
  logic [NW-1:0]             cw_idx;
  logic                      sys_bit;
  logic                      par_bit;

  always_comb begin
    stop_eff = (cnt_stop_val > N_C) ? N_C : cnt_stop_val;
    step     = cnt_en && (cnt_q < stop_eff);
    sys_ph   = cnt_q < K_C;
    info_idx = KW'(cnt_q);
    cw_idx   = NW'(cnt_q);
    // info_q is not loaded yet at c=0, so bit 0 bypasses it
    sys_bit  = (cnt_q == '0) ? mul_info_bits[0]
                             : info_q[info_idx];
    par_bit  = ^(info_q & grow_q);

    cnt_d  = cnt_q;
    info_d = info_q;
    grow_d = grow_q;
    cw_d   = cw_q;

    if (step) begin
      cnt_d = cnt_q + COUNT_MAX_BITS'(1);
      if (cnt_q == '0) begin
        info_d = mul_info_bits;
      end
      if (sys_ph) begin
        cw_d[cw_idx] = sys_bit;
      end else begin
        cw_d[cw_idx] = par_bit;
        grow_d = {grow_q[K-2:0], grow_q[K-1]};
      end
    end
  end

  always_ff @(posedge clk or negedge cnt_rst) begin
    if (!cnt_rst) begin
      cnt_q  <= '0;
      info_q <= '0;
      grow_q <= GEN_ROW0;
      cw_q   <= '0;
    end else begin
      cnt_q  <= cnt_d;
      info_q <= info_d;
      grow_q <= grow_d;
      cw_q   <= cw_d;
    end
  end

  assign codeword = cw_q;

endmodule

// File: tb/tb_ldpc_encoder.sv
// Self-checking bench for ldpc_encoder: random runs against a formula model,
// plus literal expectations for the directed scenarios.
module tb_ldpc_encoder;

  localparam int N  = 2304;
  localparam int K  = 1536;
  localparam int CB = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [CB-1:0] stop = '0;
  logic [K-1:0]  info = '0;
  logic [N-1:0]  codeword;

  int tests = 0;
  int fails = 0;

  ldpc_encoder dut (
    .clk          (clk),
    .cnt_rst      (rst_n),
    .cnt_en       (en),
    .cnt_stop_val (stop),
    .mul_info_bits(info),
    .codeword     (codeword)
  );

  always #5 clk = ~clk;

  // Model: codeword position c is info[c] for c<K, else
  // p[j] = info[j mod K] ^ info[(j+1) mod K] with j=c-K.
  int           m_cnt = 0;
  logic [K-1:0] m_info = '0;
  logic [N-1:0] exp_cw = '0;

  always @(posedge clk or negedge rst_n) begin
    int s;
    int j;
    if (!rst_n) begin
      m_cnt  = 0;
      m_info = '0;
      exp_cw = '0;
    end else begin
      s = (int'(stop) > N) ? N : int'(stop);
      if (en && m_cnt < s) begin
        if (m_cnt == 0) m_info = info;
        if (m_cnt < K) begin
          exp_cw[m_cnt] = m_info[m_cnt];
        end else begin
          j = m_cnt - K;
          exp_cw[m_cnt] = m_info[j % K] ^ m_info[(j + 1) % K];
        end
        m_cnt++;
      end
    end
  end

  function automatic int first_diff(input logic [N-1:0] a,
                                    input logic [N-1:0] b);
    for (int i = 0; i < N; i++)
      if (a[i] !== b[i]) return i;
    return -1;
  endfunction

  always @(negedge clk) begin
    int d;
    tests++;
    if (codeword !== exp_cw) begin
      fails++;
      d = first_diff(codeword, exp_cw);
      if (fails < 20)
        $display("FAIL model_cycle t=%0t bit %0d got %b want %b",
                 $time, d, codeword[d], exp_cw[d]);
    end
  end

  task automatic chk(input string name, input logic [N-1:0] want);
    int d;
    tests++;
    if (codeword !== want) begin
      fails++;
      d = first_diff(codeword, want);
      $display("FAIL %s bit %0d got %b want %b",
               name, d, codeword[d], want[d]);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    en    = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // mode 0 plain, 1 gate at c=1000 for 50, 2 info->0 at c=10,
  // 3 random enable, 4 lower stop to 300 at cycle 700
  task automatic run(input logic [K-1:0] inf, input int stop_v,
                     input int ncyc, input int mode);
    do_reset();
    info = inf;
    stop = CB'(stop_v);
    for (int i = 0; i < ncyc; i++) begin
      case (mode)
        1:       en = !(i >= 1000 && i < 1050);
        3:       en = ($urandom_range(0, 3) != 0);
        default: en = 1'b1;
      endcase
      if (mode == 2 && i == 10) info = '0;
      if (mode == 4 && i == 700) stop = CB'(300);
      if (mode == 3 && i > 0) info = {K/32{$urandom()}};
      @(posedge clk); #1;
    end
    @(negedge clk);
  endtask

  function automatic logic [K-1:0] rnd_info();
    logic [K-1:0] v;
    for (int w = 0; w < K / 32; w++) v[w*32 +: 32] = $urandom();
    return v;
  endfunction

  logic [N-1:0] lit_3f;
  logic [N-1:0] lit_part;
  logic [N-1:0] zero_v;
  logic [K-1:0] ones_k;

  initial begin
    zero_v = '0;
    lit_3f = '0;
    lit_3f[5:0] = 6'h3f;
    lit_3f[K + 5] = 1'b1;
    ones_k = '1;
    lit_part = '0;
    lit_part[K-1:0] = ones_k;

    // reset held with clocks running
    info = {K{1'b1}};
    stop = CB'(N);
    en   = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("reset_hold", zero_v);
    #1 rst_n = 1'b1;
    en = 1'b0;

    // full encode of 0x3F, then saturation
    run(K'(6'h3f), N, N, 0);
    chk("full_3f", lit_3f);
    repeat (100) @(posedge clk);
    @(negedge clk);
    chk("saturate", lit_3f);

    // async reset mid-encode, no clock edge needed
    do_reset();
    info = {K{1'b1}};
    stop = CB'(N);
    en = 1'b1;
    repeat (100) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", zero_v);
    en = 1'b0;

    // enable gating
    run(K'(6'h3f), N, N + 50, 1);
    chk("gated_3f", lit_3f);

    // input change after capture
    run(K'(6'h3f), N, N, 2);
    chk("info_change", lit_3f);

    // partial stop with all-ones info
    run(ones_k, 1540, N + 10, 0);
    chk("partial_1540", lit_part);

    // stop above N saturates to N
    run(rnd_info(), 4095, N + 20, 0);

    // random runs, random enable
    run(rnd_info(), N, 3200, 3);
    run(rnd_info(), $urandom_range(1, N - 1), 3200, 3);
    run(rnd_info(), K, 2000, 3);
    run(rnd_info(), 0, 50, 3);

    // stop lowered below current count freezes
    run(rnd_info(), N, 1000, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ldpc_encoder.md
# ldpc_encoder

Systematic, bit-serial LDPC block encoder for the (N=2304, K=1536) rate-2/3 code path. It copies the K information bits into the codeword first, then produces the N−K parity bits. Each parity bit is the mod-2 product of the information vector with one row of a circulant generator. An internal cycle counter sequences the work at one codeword bit per enabled clock. The block sits between the information-bit source and the modulator/output buffer, and exposes the full parallel codeword.

## Interface
- N, 2304, codeword length in bits.
- K, 1536, information length in bits; parity length M = N−K (768).
- COUNT_MAX_BITS, 12, counter width; must satisfy 2^COUNT_MAX_BITS > N.
- GEN_ROW0, K-bit constant with value 3 (bits 0 and 1 set), base row of the circulant generator.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- cnt_rst  in  1  reset, asynchronous, active-low; clears all state.
- cnt_en  in  1  count/encode enable; state holds when low.
- cnt_stop_val  in  COUNT_MAX_BITS  counter terminal value; values above N are treated as N.
- mul_info_bits  in  K  information vector to encode.
- codeword  out  N  encoded word; bit c is codeword position c.

## Operation
- Datapath state:
  - cnt: COUNT_MAX_BITS-bit counter.
  - info_q: K-bit captured information vector.
  - grow: K-bit generator-row register.
  - cw_q: N-bit codeword register; codeword = cw_q.
- Effective stop S = min(cnt_stop_val, N).
- Step rule: on each rising edge with cnt_en=1 and cnt < S, write bit position c = cnt, then cnt ← cnt+1.
- Info capture, at c = 0:
  - info_q ← mul_info_bits.
  - Bit 0 is written from mul_info_bits[0] directly, not from info_q.
- Systematic phase, 0 ≤ c < K: cw_q[c] ← info bit c. Use mul_info_bits at c = 0 and info_q afterwards.
- Parity phase, K ≤ c < N, with j = c−K:
  - cw_q[c] ← XOR-reduce(info_q AND grow).
  - Then grow ← rotate-left(grow, 1).
  - Result: parity row j = GEN_ROW0 rotated left by j.
  - With the default GEN_ROW0, p[j] = info[j mod K] XOR info[(j+1) mod K].
- Termination: when cnt = S the counter saturates and cw_q stops changing. No wrap-around. cnt_en may stay high.
- Partial encode: S < N leaves positions ≥ S at 0.
- cnt_en low: cnt, info_q, grow and cw_q all hold; encoding resumes seamlessly.
- mul_info_bits changes after c = 0 have no effect on the current codeword.
- Restart requires a reset pulse.

## Timing
- Reset (cnt_rst=0, asynchronous) state:
  - cnt = 0, info_q = 0, grow = GEN_ROW0, codeword = 0.
  - Holds for as long as cnt_rst is low.
- Reset asserted mid-encode aborts immediately; the codeword clears without waiting for a clock.
- Bit c of codeword becomes valid one clock after the edge where cnt = c with cnt_en=1.
- Full encode takes exactly N enabled cycles (2304). The codeword is final after the N-th enabled edge.
- cnt_stop_val is sampled every cycle. Lowering it below the current cnt freezes encoding at once.
- Critical path: K-input AND/XOR reduction. It is single-cycle and carries no multicycle constraint.

## Test plan
- Reset: hold cnt_rst=0 with clocks running → codeword = 0 and no bit changes. Assert cnt_rst mid-encode (cnt≈100) → codeword = 0 immediately, without waiting for a clock edge.
- Full encode with mul_info_bits = 0x3F, cnt_stop_val = 2304, cnt_en = 1 after reset release. After 2304 edges, require:
  - codeword[5:0] = 6'b111111 and codeword[1535:6] = 0.
  - Parity bits = codeword[1541] only, since p[5] = info5^info6 = 1; every other parity bit = 0.
- Saturation: continue clocking 100 more cycles after completion → codeword unchanged, cnt stays at 2304.
- Enable gating: deassert cnt_en for 50 cycles at c=1000, then resume → final codeword identical to the uninterrupted run.
- Partial stop: cnt_stop_val = 1540 with all-ones info. Require:
  - codeword[1535:0] all ones.
  - Parity bits 1536–1539 = 0 (each is 1^1).
  - codeword[2303:1540] = 0.
- Input stability: change mul_info_bits to 0 at c=10 during the 0x3F run → codeword identical to the unchanged-input case.
